// File: rtl/adc_pll_pkg.sv
// adc_pll_pkg
// Shared definitions for the ADC PLL sequencer:
//   - state_e        : FSM state encoding (3 bits, OFF..FAIL)
//   - *_DEF          : default timing constants for a 24 MHz reference clock
//   - CNT_W / RTY_W  : phase counter and retry counter widths
//   - RELOCK_W       : width of the lock-loss statistics counter
//   - sat_inc_relock : saturating increment for the lock-loss counter
package adc_pll_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_SBY    = 3'd5,
    ST_FAIL   = 3'd6
  } state_e;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned RTY_W    = 4;
  localparam int unsigned RELOCK_W = 8;

  // 1 us reset, 1 ms lock timeout, ~10 us stability window at 24 MHz.
  localparam int unsigned RST_CYC_DEF    = 24;
  localparam int unsigned LOCK_TMO_DEF   = 24000;
  localparam int unsigned STABLE_CYC_DEF = 256;
  localparam int unsigned RETRY_MAX_DEF  = 3;

  function automatic logic [RELOCK_W-1:0] sat_inc_relock(input logic [RELOCK_W-1:0] v);
    return (v == {RELOCK_W{1'b1}}) ? v : v + RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/adc_pll_sync.sv
// adc_pll_sync
// Two-flop synchronizer bringing asynchronous level signals into clk.
// Ports:
//   clk   in          destination clock
//   rst_n in          asynchronous active-low reset, flops clear to 0
//   d_i   in  WIDTH   asynchronous inputs
//   q_o   out WIDTH   synchronized outputs (2 clk of latency)
module adc_pll_sync
  import adc_pll_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Bits are independent: no cross-bit coherency is implied.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q[gi] <= 1'b0;
        sync_q[gi] <= 1'b0;
      end else begin
        meta_q[gi] <= d_i[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc_pll_ctrl.sv
// adc_pll_ctrl
// Sequencer for the ADC PLL: timed reset, lock wait with timeout and retry,
// lock-stability qualification, standby handling and lock-loss recovery.
// A sticky failure is raised after RETRY_MAX consecutive lock timeouts.
// Build option: define ADC_PLL_CTRL_STAT_EN to make relock_cnt and state
// live; otherwise both read 0 and the lock-loss counter is not built.
// Ports:
//   clk        in      PLL reference clock, clocks all logic
//   rst_n      in      asynchronous active-low reset
//   en         in      run request; 0 forces OFF
//   sby_req    in      standby request (level)
//   pll_lock   in      PLL extlock, asynchronous to clk
//   pll_reset  out     PLL reset, active high
//   pll_stdby  out     PLL standby, active high
//   adc_rdy    out     lock stable, ADC clock usable
//   pll_fail   out     sticky lock failure (cleared in OFF)
//   relock_cnt out 8   saturating lock-loss count while in RUN
//   state      out 3   current FSM state encoding
module adc_pll_ctrl
  import adc_pll_pkg::*;
#(
  parameter int unsigned RST_CYC    = RST_CYC_DEF,
  parameter int unsigned LOCK_TMO   = LOCK_TMO_DEF,
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEF,
  parameter int unsigned RETRY_MAX  = RETRY_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sby_req,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic                pll_stdby,
  output logic                adc_rdy,
  output logic                pll_fail,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic [STATE_W-1:0]  state
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(RETRY_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [RTY_W-1:0] rty_inc;
  logic             lock_s;

  adc_pll_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    rty_d   = rty_q;
    rty_inc = rty_q + RTY_W'(1);

    if (state_q == ST_OFF) begin
      rty_d = '0;
    end

    if (!en) begin
      state_d = ST_OFF;
    end else if (sby_req && (state_q inside {ST_RST, ST_WAIT, ST_STABLE, ST_RUN})) begin
      state_d = ST_SBY;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (!sby_req) state_d = ST_RST;
        end
        ST_RST: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TMO_LAST) begin
            rty_d   = rty_inc;
            state_d = (rty_inc == RTY_LIMIT) ? ST_FAIL : ST_RST;
          end
        end
        ST_STABLE: begin
          // A dropout returns to WAIT; the state change restarts cnt and
          // thereby the lock timeout.
          if (!lock_s) begin
            state_d = ST_WAIT;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            rty_d   = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) state_d = ST_RST;
        end
        ST_SBY: begin
          // Always re-reset the PLL when leaving standby.
          if (!sby_req) state_d = ST_RST;
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end

    // One shared phase counter, restarted on every state change.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
    end
  end

  // All outputs decode the state register only: no input-to-output path.
  assign pll_reset = (state_q == ST_OFF) || (state_q == ST_RST) || (state_q == ST_FAIL);
  assign pll_stdby = (state_q == ST_SBY);
  assign adc_rdy   = (state_q == ST_RUN);
  assign pll_fail  = (state_q == ST_FAIL);

`ifdef ADC_PLL_CTRL_STAT_EN
  logic                relock_evt;
  logic [RELOCK_W-1:0] relock_q;

  // RUN can only reach RST through lock loss; standby and en=0 take other
  // exits, so a simultaneous standby request never counts as a relock.
  assign relock_evt = (state_q == ST_RUN) && (state_d == ST_RST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_q <= '0;
    end else if (relock_evt) begin
      relock_q <= sat_inc_relock(relock_q);
    end
  end

  assign relock_cnt = relock_q;
  assign state      = state_q;
`else
  assign relock_cnt = '0;
  assign state      = '0;
`endif

endmodule

// File: tb/tb_adc_pll_ctrl.sv
// tb_adc_pll_ctrl
// Scoreboard bench for adc_pll_ctrl. Stimulus advances a behavioural model
// one clock per transaction and queues the expected outputs; a monitor pops
// and compares on each falling edge, and checks reset values whenever rst_n
// is low.
module tb_adc_pll_ctrl;

  localparam int RST_CYC    = 4;
  localparam int LOCK_TMO   = 20;
  localparam int STABLE_CYC = 8;
  localparam int RETRY_MAX  = 2;
`ifdef ADC_PLL_CTRL_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  // Spec state numbering.
  localparam int P_OFF = 0, P_RST = 1, P_WAIT = 2, P_STABLE = 3, P_RUN = 4, P_SBY = 5, P_FAIL = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       sby_req = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, pll_stdby, adc_rdy, pll_fail;
  logic [7:0] relock_cnt;
  logic [2:0] state;

  adc_pll_ctrl #(
    .RST_CYC    (RST_CYC),
    .LOCK_TMO   (LOCK_TMO),
    .STABLE_CYC (STABLE_CYC),
    .RETRY_MAX  (RETRY_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sby_req    (sby_req),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_stdby  (pll_stdby),
    .adc_rdy    (adc_rdy),
    .pll_fail   (pll_fail),
    .relock_cnt (relock_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       sby;
    logic       rdy;
    logic       fail;
    logic [2:0] st;
    logic [7:0] rc;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: phase plus a countdown of cycles left in that phase,
  // a two-deep lock delay line, the number of failed attempts and the
  // lock-loss tally.
  int m_ph, m_left, m_lk1, m_lk2, m_fails, m_relock;

  task automatic m_reset();
    m_ph = P_OFF; m_left = 0; m_lk1 = 0; m_lk2 = 0; m_fails = 0; m_relock = 0;
  endtask

  task automatic m_step(input logic e, input logic s, input logic l);
    int seen, nxt;
    seen  = m_lk2;
    m_lk2 = m_lk1;
    m_lk1 = int'(l);
    nxt   = m_ph;
    if (m_ph == P_OFF) m_fails = 0;
    if (!e) begin
      nxt = P_OFF;
    end else if (s && m_ph >= P_RST && m_ph <= P_RUN) begin
      nxt = P_SBY;
    end else if (m_ph == P_OFF) begin
      if (!s) nxt = P_RST;
    end else if (m_ph == P_RST) begin
      m_left--;
      if (m_left == 0) nxt = P_WAIT;
    end else if (m_ph == P_WAIT) begin
      if (seen != 0) begin
        nxt = P_STABLE;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_fails++;
          nxt = (m_fails == RETRY_MAX) ? P_FAIL : P_RST;
        end
      end
    end else if (m_ph == P_STABLE) begin
      if (seen == 0) begin
        nxt = P_WAIT;
      end else begin
        m_left--;
        if (m_left == 0) begin
          nxt = P_RUN;
          m_fails = 0;
        end
      end
    end else if (m_ph == P_RUN) begin
      if (seen == 0) begin
        nxt = P_RST;
        if (m_relock < 255) m_relock++;
      end
    end else if (m_ph == P_SBY) begin
      if (!s) nxt = P_RST;
    end
    if (nxt != m_ph) begin
      m_left = (nxt == P_RST) ? RST_CYC : (nxt == P_WAIT) ? LOCK_TMO : STABLE_CYC;
    end
    m_ph = nxt;
  endtask

  function automatic obs_t m_expect();
    obs_t o;
    o.rst  = (m_ph == P_OFF) || (m_ph == P_RST) || (m_ph == P_FAIL);
    o.sby  = (m_ph == P_SBY);
    o.rdy  = (m_ph == P_RUN);
    o.fail = (m_ph == P_FAIL);
    o.st   = STAT ? 3'(m_ph) : 3'd0;
    o.rc   = STAT ? 8'(m_relock) : 8'd0;
    return o;
  endfunction

  // One transaction per clock: capture inputs, let the edge happen, advance
  // the model, queue the expected outputs.
  task automatic tick(input int n);
    logic e, s, l;
    for (int k = 0; k < n; k++) begin
      e = en; s = sby_req; l = pll_lock;
      @(posedge clk);
      #1;
      m_step(e, s, l);
      exp_q.push_back(m_expect());
    end
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2;
    m_reset();
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard.
  initial begin
    obs_t act, want;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        exp_q.delete();
        act  = {pll_reset, pll_stdby, adc_rdy, pll_fail, state, relock_cnt};
        want = '{rst: 1'b1, sby: 1'b0, rdy: 1'b0, fail: 1'b0, st: 3'd0, rc: 8'd0};
        n_cmp++;
        if (act !== want) begin
          n_bad++;
          $display("FAIL reset_state t=%0t got rst=%b sby=%b rdy=%b fail=%b st=%0d rc=%0d want rst=1 sby=0 rdy=0 fail=0 st=0 rc=0",
                   $time, act.rst, act.sby, act.rdy, act.fail, act.st, act.rc);
        end
      end else if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        act  = {pll_reset, pll_stdby, adc_rdy, pll_fail, state, relock_cnt};
        n_cmp++;
        if (act !== want) begin
          n_bad++;
          $display("FAIL outputs t=%0t got rst=%b sby=%b rdy=%b fail=%b st=%0d rc=%0d want rst=%b sby=%b rdy=%b fail=%b st=%0d rc=%0d",
                   $time, act.rst, act.sby, act.rdy, act.fail, act.st, act.rc,
                   want.rst, want.sby, want.rdy, want.fail, want.st, want.rc);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int g;
    m_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Power-up: lock arrives 10 cycles after RST exit.
    en = 1'b1;
    tick(1 + RST_CYC + 10);
    pll_lock = 1'b1;
    tick(3 + STABLE_CYC + 6);
    $display("scenario power_up done, compared %0d", n_cmp);

    // Lock never arrives: two attempts then FAIL, then en pulse clears it.
    en = 1'b0; pll_lock = 1'b0;
    tick(2);
    en = 1'b1;
    tick(RETRY_MAX * (RST_CYC + LOCK_TMO) + 8);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(8);
    $display("scenario lock_timeout done, compared %0d", n_cmp);

    // Lock glitch during STABLE.
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1 + RST_CYC + 3);
    pll_lock = 1'b1;
    tick(3 + 5);
    pll_lock = 1'b0;
    tick(2);
    pll_lock = 1'b1;
    tick(3 + STABLE_CYC + 6);
    $display("scenario lock_glitch done, compared %0d", n_cmp);

    // Three lock drops in RUN, each relocking.
    for (int i = 0; i < 3; i++) begin
      pll_lock = 1'b0;
      g = $urandom_range(1, 3);
      tick(g);
      pll_lock = 1'b1;
      tick(RST_CYC + STABLE_CYC + 12);
    end
    $display("scenario relock_x3 done, compared %0d", n_cmp);

    // Standby request coinciding with lock loss as seen by the FSM.
    pll_lock = 1'b0;
    tick(2);
    sby_req = 1'b1;
    tick(4);
    sby_req = 1'b0;
    pll_lock = 1'b1;
    tick(RST_CYC + STABLE_CYC + 12);
    $display("scenario sby_vs_loss done, compared %0d", n_cmp);

    // Saturation of the lock-loss counter.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(RST_CYC + STABLE_CYC + 10);
    end
    $display("scenario relock_sat done, compared %0d", n_cmp);

    // Asynchronous reset while in WAIT.
    en = 1'b0; pll_lock = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1 + RST_CYC + 4);
    async_rst();
    tick(RST_CYC + LOCK_TMO + 6);
    $display("scenario async_reset done, compared %0d", n_cmp);

    // Randomised traffic, alternating fast and slow lock activity.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 119) == 0) sby_req = ~sby_req;
      if (((i / 500) % 2) == 0) begin
        if ($urandom_range(0, 9) == 0) pll_lock = ~pll_lock;
      end else begin
        if ($urandom_range(0, 69) == 0) pll_lock = ~pll_lock;
      end
      if ($urandom_range(0, 999) == 0) async_rst();
      tick(1);
    end
    $display("scenario random done, compared %0d", n_cmp);

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_pll_ctrl.md
# adc_pll_ctrl

Sequencer that drives the ADC PLL's `reset`/`stdby` inputs and monitors its `extlock`. Runs on the PLL reference clock (24 MHz) and applies a timed reset, waits for lock with a timeout and retries. It qualifies lock stability and publishes a registered `adc_rdy` that gates the 16 MHz ADC domain. It also handles standby requests and lock-loss recovery, and raises a sticky failure flag after repeated lock timeouts.

## Interface
Parameters:
- `RST_CYC`, 24: PLL reset pulse width in clk cycles (1..65535).
- `LOCK_TMO`, 24000: max cycles to wait for lock per attempt (1..65535).
- `STABLE_CYC`, 256: cycles the lock must stay high continuously before ready (1..65535).
- `RETRY_MAX`, 3: lock attempts before FAIL (1..15).

Ports:
- `clk`  in  1  PLL reference clock; drives all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  request PLL running; 0 forces OFF.
- `sby_req`  in  1  request PLL standby (level).
- `pll_lock`  in  1  PLL extlock; asynchronous to clk.
- `pll_reset`  out  1  to PLL reset, active high.
- `pll_stdby`  out  1  to PLL stdby, active high.
- `adc_rdy`  out  1  lock stable, ADC clock usable.
- `pll_fail`  out  1  sticky lock failure.
- `relock_cnt`  out  8  saturating count of lock losses in RUN.
- `state`  out  3  current FSM state encoding.

## Operation
- `pll_lock` passes a 2-FF synchronizer to give `lock_s`. The FSM uses `lock_s` only.
- A single 16-bit counter `cnt` is cleared on every state change. A retry counter `rty` is 4 bits.
- Encoding: OFF=0, RST=1, WAIT=2, STABLE=3, RUN=4, SBY=5, FAIL=6.
- Global priority, every state: `en`=0 → OFF. Otherwise `sby_req`=1 in RST/WAIT/STABLE/RUN → SBY. Otherwise the per-state rules below apply.
- OFF: `pll_reset`=1. Clears `rty` and `pll_fail`. Leaves for RST when `en`=1 and `sby_req`=0.
- RST: `pll_reset`=1. Moves to WAIT when `cnt`==RST_CYC-1.
- WAIT: `pll_reset`=0.
  - `lock_s`=1 → STABLE.
  - Else when `cnt`==LOCK_TMO-1, `rty` increments. If the incremented value equals RETRY_MAX → FAIL, else → RST.
- STABLE:
  - `lock_s`=0 → WAIT, with `cnt` restarted; the timeout restarts.
  - `cnt`==STABLE_CYC-1 with `lock_s`=1 → RUN, and `rty` clears.
- RUN: `adc_rdy`=1. `lock_s`=0 → RST and `relock_cnt` increments, saturating at 255.
- SBY: `pll_stdby`=1, `pll_reset`=0. When `sby_req`=0 → RST; the PLL is always re-reset after standby.
- FAIL: `pll_fail`=1, `pll_reset`=1. Exits only via `en`=0 → OFF.
- Simultaneous `sby_req` and lock loss in RUN: SBY wins, and `relock_cnt` does not increment.
- `relock_cnt` is cleared only by `rst_n`.

## Timing
- Reset values: state=OFF, `pll_reset`=1, `pll_stdby`=0, `adc_rdy`=0, `pll_fail`=0, `relock_cnt`=0, `cnt`=0, `rty`=0, sync FFs=0.
- All outputs are registered or decoded from the state register only. There is no combinational input→output path.
- Entry to RST with `en`=1 gives exactly RST_CYC cycles of `pll_reset`=1.
- `pll_lock` rise to STABLE entry takes 3 cycles: 2 sync + 1 FSM. STABLE→RUN takes STABLE_CYC cycles.
- Lock loss in RUN: `adc_rdy` falls 3 cycles after the `pll_lock` fall.
- `en` fall: OFF is entered and `adc_rdy`=0 on the next clock edge.
- Asserting `rst_n` mid-sequence immediately forces `pll_reset`=1 (asynchronous).

## Configuration
- `ADC_PLL_CTRL_STAT_EN` defined: the `relock_cnt` counter and `state` output are live.
- Not defined: `relock_cnt` and `state` are tied to 0 and the counter register is not built. FSM behaviour is otherwise identical. The ports exist in both builds.

## Structure
- Package `adc_pll_pkg`:
  - state enum / localparams (OFF..FAIL, 3 bits);
  - default timing constants;
  - counter width 16;
  - `relock_cnt` width 8.
- One sub-module, `adc_pll_sync`: 2-FF synchronizer with async active-low reset to 0. It is instantiated for `pll_lock`.

## Test plan
Use RST_CYC=4, LOCK_TMO=20, STABLE_CYC=8, RETRY_MAX=2 unless stated.
- Power-up: release `rst_n`, `en`=1, `pll_lock` rises 10 cycles after RST exit → `pll_reset` high exactly 4 cycles, then `adc_rdy`=1 3+8 cycles after the `pll_lock` rise.
- Lock never arrives → two RST/WAIT attempts of 4+20 cycles each, then state=6, `pll_fail`=1, `pll_reset`=1. Then `en`=0 for 1 cycle, then 1 → OFF→RST with `pll_fail`=0.
- Lock glitch: in STABLE, `pll_lock` low for 2 cycles at cycle 5 → back to WAIT, no RUN. `adc_rdy` rises only after 8 clean cycles.
- In RUN, drop `pll_lock` three times (each relocks) → `relock_cnt`=3, each drop re-enters RST. With 300 drops → `relock_cnt` saturates at 255.
- In RUN, assert `sby_req` and drop `pll_lock` in the same cycle → SBY, `pll_stdby`=1, `relock_cnt` unchanged. Release `sby_req` → RST for 4 cycles.
- Assert `rst_n`=0 while in WAIT → `pll_reset`=1 and `adc_rdy`=0 asynchronously, state=0. Build without `ADC_PLL_CTRL_STAT_EN` → `relock_cnt`/`state` read 0 throughout.
